// File: rtl/vga_timing_pkg.sv
// vga_timing_gen shared constants and helpers.
// Default geometry is 640x480@60 with a 25.175 MHz pixel rate.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_CW       = 11;

  function automatic bit total_fits(
    input int unsigned total,
    input int unsigned cw
  );
    return 64'(total) <= (64'd1 << cw);
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrap counter plus registered sync decode.
// Decodes are taken from the next-state count to stay aligned with it.
import vga_timing_pkg::*;

module timing_axis #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BACK   = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic [CW-1:0] nxt,
  output logic          sync,
  output logic          active,
  output logic          wrap
);

  localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

  // One extra bit so bounds equal to 2^CW still compare correctly.
  localparam logic [CW:0] LAST   = (CW+1)'(TOTAL - 1);
  localparam logic [CW:0] A_END  = (CW+1)'(ACTIVE);
  localparam logic [CW:0] S_BEG  = (CW+1)'(ACTIVE + FRONT);
  localparam logic [CW:0] S_END  = (CW+1)'(ACTIVE + FRONT + SYNC);

  if (!total_fits(TOTAL, CW)) begin : g_too_wide
    $error("timing_axis: TOTAL does not fit in CW bits");
  end

  logic [CW:0] nxt_w;
  logic        in_sync;

  assign wrap    = ({1'b0, count} == LAST);
  assign nxt     = !en  ? count :
                   wrap ? '0    :
                          count + CW'(1);
  assign nxt_w   = {1'b0, nxt};
  assign active  = (nxt_w < A_END);
  assign in_sync = (nxt_w >= S_BEG) && (nxt_w < S_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LAST[CW-1:0];
      sync  <= ~POL;
    end else begin
      count <= nxt;
      sync  <= in_sync ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-rate enable.
// Reset parks on the last pixel so the first tick lands on (0,0).
import vga_timing_pkg::*;

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          frame_start,
  output logic          line_start
);

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt_unused;
  logic          h_active;
  logic          v_active;
  logic          h_wrap;
  logic          v_wrap;
  logic          v_en;

  assign v_en = pix_en & h_wrap;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (H_POL),
    .CW     (CW)
  ) u_h (
    .clk    (Clk),
    .rst    (reset),
    .en     (pix_en),
    .count  (hcount),
    .nxt    (h_nxt),
    .sync   (hsync),
    .active (h_active),
    .wrap   (h_wrap)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (V_POL),
    .CW     (CW)
  ) u_v (
    .clk    (Clk),
    .rst    (reset),
    .en     (v_en),
    .count  (vcount),
    .nxt    (v_nxt_unused),
    .sync   (vsync),
    .active (v_active),
    .wrap   (v_wrap)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      video_on    <= h_active & v_active;
      line_start  <= pix_en & (h_nxt == '0);
      frame_start <= v_en & v_wrap;
    end
  end

endmodule
